// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, MixColumns FSM states and
// row-major state byte/column access helpers.
package aes_pkg;

    localparam logic [7:0]  AES_POLY = 8'h1b;
    localparam int unsigned AES_NB   = 4;

    typedef enum logic [2:0] {
        IDLE,
        COL0,
        COL1,
        COL2,
        COL3
    } mc_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using chained xtime (covers 01..0e).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a  : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^
               (k[3] ? x8 : 8'h00);
    endfunction

    // MSB position of the byte at (row, col) in the row-major 128-bit state.
    function automatic int unsigned byte_msb(input int unsigned row, input int unsigned col);
        return 127 - 8 * (AES_NB * row + col);
    endfunction

    // Gather column c as {a0, a1, a2, a3}, a0 in the top byte.
    function automatic logic [31:0] get_col(input logic [127:0] s, input int unsigned c);
        logic [31:0] col;
        col = '0;
        for (int unsigned r = 0; r < AES_NB; r++) begin
            col[31 - 8 * r -: 8] = s[byte_msb(r, c) -: 8];
        end
        return col;
    endfunction

    // Scatter a {b0, b1, b2, b3} word back into column c of the state.
    function automatic logic [127:0] put_col(input logic [127:0] s, input int unsigned c,
                                             input logic [31:0] col);
        logic [127:0] res;
        res = s;
        for (int unsigned r = 0; r < AES_NB; r++) begin
            res[byte_msb(r, c) -: 8] = col[31 - 8 * r -: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mixcol_word.sv
// Single-column MixColumns mixer, purely combinational.
// Column word is {a0, a1, a2, a3} with a0 in bits [31:24].
// MIXCOL_INV_EN adds the i_inv input selecting InvMixColumns coefficients.
module mixcol_word
    import aes_pkg::*;
(
`ifdef MIXCOL_INV_EN
    input  logic        i_inv,
`endif
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a [4];
    logic [7:0] w_b [4];

    // Split the input word into bytes and form each output byte from the
    // rotated coefficient row, then repack.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_a[k] = i_col[31 - 8 * k -: 8];
        end
        for (int unsigned k = 0; k < 4; k++) begin
            w_b[k] = xtime(w_a[k]) ^
                     xtime(w_a[(k + 1) % 4]) ^ w_a[(k + 1) % 4] ^
                     w_a[(k + 2) % 4] ^
                     w_a[(k + 3) % 4];
`ifdef MIXCOL_INV_EN
            if (i_inv) begin
                w_b[k] = gmul(w_a[k],           4'he) ^
                         gmul(w_a[(k + 1) % 4], 4'hb) ^
                         gmul(w_a[(k + 2) % 4], 4'hd) ^
                         gmul(w_a[(k + 3) % 4], 4'h9);
            end
`endif
        end
        o_col = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o_col[31 - 8 * k -: 8] = w_b[k];
        end
    end

endmodule

// File: rtl/mix_columns.sv
// Iterative AES MixColumns: latches a state on start_in, mixes one column
// per clock through a single shared mixcol_word, then pulses ready_out.
// MIXCOL_INV_EN adds the decrypt_in port and InvMixColumns support.
module mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [127:0] data_in,
`ifdef MIXCOL_INV_EN
    input  logic         decrypt_in,
`endif
    output logic [127:0] data_out,
    output logic         ready_out,
    output logic         busy_out
);

    mc_state_t    r_state;
    mc_state_t    w_state_next;
    logic [127:0] r_work;
    logic [127:0] r_data_out;
    logic         r_ready;
    logic [1:0]   w_col_idx;
    logic         w_accept;
    logic         w_col_active;
    logic         w_last;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;
    logic [127:0] w_work_mixed;
`ifdef MIXCOL_INV_EN
    logic         r_inv;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state column select / control strobes.
    always_comb begin
        w_state_next = r_state;
        w_col_idx    = '0;
        w_accept     = 1'b0;
        w_col_active = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_accept     = 1'b1;
                    w_state_next = COL0;
                end
            end
            COL0: begin
                w_col_idx    = 2'd0;
                w_col_active = 1'b1;
                w_state_next = COL1;
            end
            COL1: begin
                w_col_idx    = 2'd1;
                w_col_active = 1'b1;
                w_state_next = COL2;
            end
            COL2: begin
                w_col_idx    = 2'd2;
                w_col_active = 1'b1;
                w_state_next = COL3;
            end
            COL3: begin
                w_col_idx    = 2'd3;
                w_col_active = 1'b1;
                w_last       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_col_in     = get_col(r_work, {30'd0, w_col_idx});
    assign w_work_mixed = put_col(r_work, {30'd0, w_col_idx}, w_col_out);

    mixcol_word u_mixcol_word (
`ifdef MIXCOL_INV_EN
        .i_inv (r_inv),
`endif
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    // Work register: load on accept, then overwrite one column per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
        end else if (w_col_active) begin
            r_work <= w_work_mixed;
        end
    end

`ifdef MIXCOL_INV_EN
    // Direction flag captured together with the accepted state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= decrypt_in;
        end
    end
`endif

    // Result register and one-cycle ready pulse, loaded on the last column.
    // The final column is taken straight from the mixer so data_out is
    // complete in the same cycle the work register finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= w_last;
            if (w_last) begin
                r_data_out <= w_work_mixed;
            end
        end
    end

    assign data_out  = r_data_out;
    assign ready_out = r_ready;
    assign busy_out  = (r_state != IDLE);

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns against a matrix-product reference
// model over GF(2^8). Inverse tests run only when MIXCOL_INV_EN is defined.
module tb_mix_columns;

    logic         clk;
    logic         rst;
    logic         start_in;
    logic [127:0] data_in;
`ifdef MIXCOL_INV_EN
    logic         decrypt_in;
`endif
    logic [127:0] data_out;
    logic         ready_out;
    logic         busy_out;

    int checks;
    int failures;

    mix_columns dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .data_in    (data_in),
`ifdef MIXCOL_INV_EN
        .decrypt_in (decrypt_in),
`endif
        .data_out   (data_out),
        .ready_out  (ready_out),
        .busy_out   (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        end
        return p[7:0];
    endfunction

    // Circulant matrix times each state column.
    function automatic logic [127:0] model_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   st [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) st[i] = s[127 - 8 * i -: 8];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(coef[(j - r) & 3], st[4 * j + c]);
                end
                res[127 - 8 * (4 * r + c) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one block, scramble data_in after acceptance, wait for ready.
    task automatic run_block(input logic [127:0] d, input bit inv,
                             output logic [127:0] got, output int lat, output bit busy_seen);
        @(negedge clk);
        start_in = 1'b1;
        data_in  = d;
`ifdef MIXCOL_INV_EN
        decrypt_in = inv;
`endif
        @(negedge clk);
        start_in  = 1'b0;
        data_in   = rand128();
`ifdef MIXCOL_INV_EN
        decrypt_in = ~inv;
`endif
        busy_seen = busy_out;
        lat = 1;
        while (!ready_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = data_out;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_in = 1'b0;
        data_in = '0;
`ifdef MIXCOL_INV_EN
        decrypt_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== '0 || ready_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: data_out=%h ready=%b busy=%b, required 0/0/0",
                     data_out, ready_out, busy_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_block(input string name, input logic [127:0] d, input bit inv);
        logic [127:0] got;
        logic [127:0] exp;
        int lat;
        bit busy_seen;
        exp = model_mix(d, inv);
        run_block(d, inv, got, lat, busy_seen);
        checks++;
        if (lat !== 5 || busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL %s_timing: latency=%0d busy=%b, required latency=5 busy=1",
                     name, lat, busy_seen);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_data: data_out=%h, required %h", name, got, exp);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: ready=%b busy=%b, required 0/0", name, ready_out, busy_out);
        end
    endtask

    task automatic test_fips_vector();
        logic [127:0] got;
        int lat;
        bit busy_seen;
        run_block(128'hdbf201c6_130a01c6_532201c6_455c01c6, 1'b0, got, lat, busy_seen);
        checks++;
        if (got !== 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6 || lat !== 5) begin
            failures++;
            $display("FAIL fips_forward: data_out=%h lat=%0d, required 8e9f01c64ddc01c6a15801c6bc9d01c6 lat=5",
                     got, lat);
        end
    endtask

`ifdef MIXCOL_INV_EN
    task automatic test_inverse();
        logic [127:0] got;
        int lat;
        bit busy_seen;
        run_block(128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, 1'b1, got, lat, busy_seen);
        checks++;
        if (got !== 128'hdbf201c6_130a01c6_532201c6_455c01c6 || lat !== 5) begin
            failures++;
            $display("FAIL fips_inverse: data_out=%h lat=%0d, required dbf201c6130a01c6532201c6455c01c6 lat=5",
                     got, lat);
        end
        for (int i = 0; i < 4; i++) check_block("rand_inv", rand128(), 1'b1);
    endtask
`endif

    task automatic test_fixed_points();
        logic [127:0] got;
        logic [127:0] d;
        int lat;
        bit busy_seen;
        d = {16{8'hc6}};
        run_block(d, 1'b0, got, lat, busy_seen);
        checks++;
        if (got !== d) begin
            failures++;
            $display("FAIL fixed_c6: data_out=%h, required %h", got, d);
        end
        d = {16{8'h01}};
        run_block(d, 1'b0, got, lat, busy_seen);
        checks++;
        if (got !== d) begin
            failures++;
            $display("FAIL fixed_01: data_out=%h, required %h", got, d);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) check_block("rand_fwd", rand128(), 1'b0);
    endtask

    task automatic test_ignored_start();
        logic [127:0] a;
        logic [127:0] got;
        int pulses;
        a = rand128();
        @(negedge clk);
        start_in = 1'b1;
        data_in  = a;
`ifdef MIXCOL_INV_EN
        decrypt_in = 1'b0;
`endif
        @(negedge clk);
        data_in = rand128();
        @(negedge clk);
        data_in = rand128();
        @(negedge clk);
        start_in = 1'b0;
        pulses = 0;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            if (ready_out) begin
                pulses++;
                got = data_out;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignored_start_pulses: pulses=%0d, required 1", pulses);
        end
        checks++;
        if (got !== model_mix(a, 1'b0)) begin
            failures++;
            $display("FAIL ignored_start_data: data_out=%h, required %h", got, model_mix(a, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] got;
        int lat;
        int gap;
        bit busy_seen;
        a = rand128();
        b = rand128();
        run_block(a, 1'b0, got, lat, busy_seen);
        checks++;
        if (got !== model_mix(a, 1'b0) || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: data_out=%h ready=%b, required %h ready=1",
                     got, ready_out, model_mix(a, 1'b0));
        end
        start_in = 1'b1;
        data_in  = b;
        @(negedge clk);
        start_in = 1'b0;
        data_in  = rand128();
        checks++;
        if (ready_out !== 1'b0 || busy_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b busy=%b, required ready=0 busy=1", ready_out, busy_out);
        end
        gap = 1;
        while (!ready_out && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap !== 5) begin
            failures++;
            $display("FAIL b2b_gap: pulse spacing=%0d, required 5", gap);
        end
        checks++;
        if (data_out !== model_mix(b, 1'b0)) begin
            failures++;
            $display("FAIL b2b_second: data_out=%h, required %h", data_out, model_mix(b, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        @(negedge clk);
        start_in = 1'b1;
        data_in  = rand128();
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (data_out !== '0 || ready_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op: data_out=%h ready=%b busy=%b, required 0/0/0",
                     data_out, ready_out, busy_out);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_out || busy_out) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_no_pulse: active cycles=%0d, required 0", pulses);
        end
        check_block("after_reset", rand128(), 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fips_vector();
`ifdef MIXCOL_INV_EN
        test_inverse();
`endif
        test_fixed_points();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
